// File: rtl/id_ex_issue_register.sv
// ID/EX issue register: operand forwarding, load-use stall and bubble insertion.
// Define HAZARD_COUNT_EN to add the saturating stallCount output.
module id_ex_issue_register #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              flush,
    input  logic              idValid,
    input  logic [DATA_W-1:0] idPcPlus4,
    input  logic [DATA_W-1:0] idRsData,
    input  logic [DATA_W-1:0] idRtData,
    input  logic [DATA_W-1:0] idImmediate,
    input  logic [REG_AW-1:0] idRsAddr,
    input  logic [REG_AW-1:0] idRtAddr,
    input  logic [REG_AW-1:0] idDestAddr,
    input  logic [3:0]        idAluOperation,
    input  logic              idShift,
    input  logic              idAluImm,
    input  logic              idUsesRs,
    input  logic              idUsesRt,
    input  logic              idIsLoad,
    input  logic              idRegWrite,
    input  logic              idLink,
    input  logic [DATA_W-1:0] exAluResult,
    input  logic              exmemRegWrite,
    input  logic [REG_AW-1:0] exmemDest,
    input  logic [DATA_W-1:0] exmemValue,
    input  logic              memwbRegWrite,
    input  logic [REG_AW-1:0] memwbDest,
    input  logic [DATA_W-1:0] memwbValue,
    output logic              idStall,
    output logic              exValid,
    output logic              exRegWrite,
    output logic              exIsLoad,
    output logic [REG_AW-1:0] exDest,
    output logic [DATA_W-1:0] registerRsOrPc_4,
    output logic [DATA_W-1:0] registerRtOrZero,
    output logic [DATA_W-1:0] immediate,
    output logic [DATA_W-1:0] shiftAmount,
    output logic [3:0]        aluOperation,
    output logic              whileShiftAluInput_A_UseShamt,
    output logic              aluInput_B_UseRtOrImmeidate
`ifdef HAZARD_COUNT_EN
    ,
    output logic [31:0]       stallCount
`endif
);

    logic              loadUse;
    logic              exCanForward;
    logic              loadBubble;
    logic [DATA_W-1:0] rsForwarded;
    logic [DATA_W-1:0] rtForwarded;
    logic [DATA_W-1:0] operandA;
    logic [DATA_W-1:0] operandB;
    logic [DATA_W-1:0] shamtNext;

    always_comb begin
        loadUse = exValid & exIsLoad & exRegWrite & (exDest != '0) & idValid &
                  ((idUsesRs & (idRsAddr == exDest)) | (idUsesRt & (idRtAddr == exDest)));
    end

    assign idStall = hold | (loadUse & ~flush);

    // A load in EX has no result yet; its consumer is stalled instead of forwarded.
    assign exCanForward = exValid & exRegWrite & ~exIsLoad;

    always_comb begin
        rsForwarded = idRsData;
        if (idRsAddr != '0) begin
            if (exCanForward && (exDest == idRsAddr)) begin
                rsForwarded = exAluResult;
            end else if (exmemRegWrite && (exmemDest == idRsAddr)) begin
                rsForwarded = exmemValue;
            end else if (memwbRegWrite && (memwbDest == idRsAddr)) begin
                rsForwarded = memwbValue;
            end
        end
    end

    always_comb begin
        rtForwarded = idRtData;
        if (idRtAddr != '0) begin
            if (exCanForward && (exDest == idRtAddr)) begin
                rtForwarded = exAluResult;
            end else if (exmemRegWrite && (exmemDest == idRtAddr)) begin
                rtForwarded = exmemValue;
            end else if (memwbRegWrite && (memwbDest == idRtAddr)) begin
                rtForwarded = memwbValue;
            end
        end
    end

    assign operandA   = idLink ? idPcPlus4 : rsForwarded;
    assign operandB   = idLink ? '0 : rtForwarded;
    assign shamtNext  = {{(DATA_W - 5){1'b0}}, idImmediate[10:6]};
    assign loadBubble = flush | loadUse | ~idValid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exValid                       <= 1'b0;
            exRegWrite                    <= 1'b0;
            exIsLoad                      <= 1'b0;
            exDest                        <= '0;
            registerRsOrPc_4              <= '0;
            registerRtOrZero              <= '0;
            immediate                     <= '0;
            shiftAmount                   <= '0;
            aluOperation                  <= '0;
            whileShiftAluInput_A_UseShamt <= 1'b0;
            aluInput_B_UseRtOrImmeidate   <= 1'b0;
        end else if (!hold) begin
            if (loadBubble) begin
                exValid                       <= 1'b0;
                exRegWrite                    <= 1'b0;
                exIsLoad                      <= 1'b0;
                exDest                        <= '0;
                registerRsOrPc_4              <= '0;
                registerRtOrZero              <= '0;
                immediate                     <= '0;
                shiftAmount                   <= '0;
                aluOperation                  <= '0;
                whileShiftAluInput_A_UseShamt <= 1'b0;
                aluInput_B_UseRtOrImmeidate   <= 1'b0;
            end else begin
                exValid                       <= 1'b1;
                exRegWrite                    <= idRegWrite;
                exIsLoad                      <= idIsLoad;
                exDest                        <= idDestAddr;
                registerRsOrPc_4              <= operandA;
                registerRtOrZero              <= operandB;
                immediate                     <= idImmediate;
                shiftAmount                   <= shamtNext;
                aluOperation                  <= idAluOperation;
                whileShiftAluInput_A_UseShamt <= idShift;
                aluInput_B_UseRtOrImmeidate   <= idAluImm;
            end
        end
    end

`ifdef HAZARD_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCount <= '0;
        end else if (loadUse && !hold && !flush && (stallCount != 32'hFFFF_FFFF)) begin
            stallCount <= stallCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_issue_register.sv
// Scoreboard bench for id_ex_issue_register: stimulus pushes expectations, a monitor checks them.
// Also checks stallCount when HAZARD_COUNT_EN is defined.
module tb_id_ex_issue_register;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold, flush, idValid;
    logic [31:0] idPcPlus4, idRsData, idRtData, idImmediate;
    logic [4:0]  idRsAddr, idRtAddr, idDestAddr;
    logic [3:0]  idAluOperation;
    logic        idShift, idAluImm, idUsesRs, idUsesRt, idIsLoad, idRegWrite, idLink;
    logic [31:0] exAluResult, exmemValue, memwbValue;
    logic        exmemRegWrite, memwbRegWrite;
    logic [4:0]  exmemDest, memwbDest;
    logic        idStall, exValid, exRegWrite, exIsLoad;
    logic [4:0]  exDest;
    logic [31:0] registerRsOrPc_4, registerRtOrZero, immediate, shiftAmount;
    logic [3:0]  aluOperation;
    logic        selA, selB;
`ifdef HAZARD_COUNT_EN
    logic [31:0] stallCount;
`endif

    id_ex_issue_register dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .idValid(idValid),
        .idPcPlus4(idPcPlus4), .idRsData(idRsData), .idRtData(idRtData),
        .idImmediate(idImmediate), .idRsAddr(idRsAddr), .idRtAddr(idRtAddr),
        .idDestAddr(idDestAddr), .idAluOperation(idAluOperation), .idShift(idShift),
        .idAluImm(idAluImm), .idUsesRs(idUsesRs), .idUsesRt(idUsesRt), .idIsLoad(idIsLoad),
        .idRegWrite(idRegWrite), .idLink(idLink), .exAluResult(exAluResult),
        .exmemRegWrite(exmemRegWrite), .exmemDest(exmemDest), .exmemValue(exmemValue),
        .memwbRegWrite(memwbRegWrite), .memwbDest(memwbDest), .memwbValue(memwbValue),
        .idStall(idStall), .exValid(exValid), .exRegWrite(exRegWrite), .exIsLoad(exIsLoad),
        .exDest(exDest), .registerRsOrPc_4(registerRsOrPc_4),
        .registerRtOrZero(registerRtOrZero), .immediate(immediate),
        .shiftAmount(shiftAmount), .aluOperation(aluOperation),
        .whileShiftAluInput_A_UseShamt(selA), .aluInput_B_UseRtOrImmeidate(selB)
`ifdef HAZARD_COUNT_EN
        , .stallCount(stallCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        stall, valid, regWrite, isLoad, selA, selB;
        logic [4:0]  dest;
        logic [3:0]  op;
        logic [31:0] a, b, imm, shamt;
    } exp_t;

    exp_t sbQ[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t bubbleExp(input string n, input logic stall);
        exp_t e;
        e.name = n; e.stall = stall; e.valid = 0; e.regWrite = 0; e.isLoad = 0;
        e.selA = 0; e.selB = 0; e.dest = 0; e.op = 0; e.a = 0; e.b = 0; e.imm = 0; e.shamt = 0;
        return e;
    endfunction

    // Non-operand fields follow the ID inputs the bench itself is driving.
    function automatic exp_t capExp(input string n, input logic stall, input logic [31:0] a,
                                    input logic [31:0] b, input logic [31:0] shamt);
        exp_t e;
        e.name = n; e.stall = stall; e.valid = 1; e.regWrite = idRegWrite; e.isLoad = idIsLoad;
        e.selA = idShift; e.selB = idAluImm; e.dest = idDestAddr; e.op = idAluOperation;
        e.a = a; e.b = b; e.imm = idImmediate; e.shamt = shamt;
        return e;
    endfunction

    task automatic clearInputs();
        hold = 0; flush = 0; idValid = 0; idPcPlus4 = 0; idRsData = 0; idRtData = 0;
        idImmediate = 0; idRsAddr = 0; idRtAddr = 0; idDestAddr = 0; idAluOperation = 0;
        idShift = 0; idAluImm = 0; idUsesRs = 0; idUsesRt = 0; idIsLoad = 0; idRegWrite = 0;
        idLink = 0; exAluResult = 0; exmemRegWrite = 0; exmemDest = 0; exmemValue = 0;
        memwbRegWrite = 0; memwbDest = 0; memwbValue = 0;
    endtask

    task automatic setInstr(input logic [4:0] rs, input logic [31:0] rsD, input logic [4:0] rt,
                            input logic [31:0] rtD, input logic [4:0] dst, input logic [3:0] op);
        idValid = 1; idRsAddr = rs; idRsData = rsD; idRtAddr = rt; idRtData = rtD;
        idDestAddr = dst; idAluOperation = op; idUsesRs = 1; idUsesRt = 1; idRegWrite = 1;
        idIsLoad = 0; idLink = 0; idShift = 0; idAluImm = 0; idImmediate = 0;
    endtask

    // Push the expectation for this cycle, then advance to the next drive point.
    task automatic issue(input exp_t e);
        sbQ.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: idStall at the falling edge, registered outputs just after the next rise.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                check({e.name, ".idStall"}, 32'(idStall), 32'(e.stall));
                @(posedge clk);
                #1;
                check({e.name, ".exValid"}, 32'(exValid), 32'(e.valid));
                check({e.name, ".exRegWrite"}, 32'(exRegWrite), 32'(e.regWrite));
                check({e.name, ".exIsLoad"}, 32'(exIsLoad), 32'(e.isLoad));
                check({e.name, ".exDest"}, 32'(exDest), 32'(e.dest));
                check({e.name, ".opA"}, registerRsOrPc_4, e.a);
                check({e.name, ".opB"}, registerRtOrZero, e.b);
                check({e.name, ".imm"}, immediate, e.imm);
                check({e.name, ".shamt"}, shiftAmount, e.shamt);
                check({e.name, ".aluOp"}, 32'(aluOperation), 32'(e.op));
                check({e.name, ".selA"}, 32'(selA), 32'(e.selA));
                check({e.name, ".selB"}, 32'(selB), 32'(e.selB));
            end
        end
    end

    initial begin
        exp_t t6;
        rst_n = 0;
        clearInputs();
        #12 rst_n = 1;

        // Random traffic, then an asynchronous reset between edges.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            idValid = 1; idIsLoad = 0; idRegWrite = 1; idLink = 0;
            idRsData = $urandom; idRtData = $urandom; idImmediate = $urandom | 32'h40;
            idRsAddr = 5'($urandom); idRtAddr = 5'($urandom); idDestAddr = 5'($urandom);
            idAluOperation = 4'($urandom); idShift = 1; idAluImm = 1;
            exAluResult = $urandom; exmemValue = $urandom; memwbValue = $urandom;
        end
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        check("reset.exValid", 32'(exValid), 32'd0);
        check("reset.exRegWrite", 32'(exRegWrite), 32'd0);
        check("reset.exDest", 32'(exDest), 32'd0);
        check("reset.opA", registerRsOrPc_4, 32'd0);
        check("reset.opB", registerRtOrZero, 32'd0);
        check("reset.imm", immediate, 32'd0);
        check("reset.shamt", shiftAmount, 32'd0);
        check("reset.aluSel", {28'd0, aluOperation} | 32'(selA) | 32'(selB), 32'd0);
`ifdef HAZARD_COUNT_EN
        check("reset.stallCount", stallCount, 32'd0);
`endif
        clearInputs();
        #3 rst_n = 1;
        @(posedge clk);
        #2;

        // add $3 <- $1,$2 ; imm 0x145 has bits[10:6] = 5
        setInstr(5'd1, 32'd5, 5'd2, 32'd6, 5'd3, 4'd2);
        idImmediate = 32'h0000_0145;
        issue(capExp("addR3", 0, 32'd5, 32'd6, 32'd5));

        // sub uses $3: EX result wins over register-file 0xDEAD
        setInstr(5'd3, 32'h0000_DEAD, 5'd2, 32'd7, 5'd4, 4'd6);
        exAluResult = 32'h0000_0010;
        issue(capExp("exFwd", 0, 32'h10, 32'd7, 32'd0));

        // MEM beats WB for $5; $0 never forwarded
        setInstr(5'd5, 32'h55, 5'd0, 32'h99, 5'd6, 4'd3);
        idAluImm = 1; idImmediate = 32'hFFFF_FFF0; exAluResult = 32'hAAAA;
        exmemRegWrite = 1; exmemDest = 5'd5; exmemValue = 32'h22;
        memwbRegWrite = 1; memwbDest = 5'd5; memwbValue = 32'h33;
        issue(capExp("memPrio", 0, 32'h22, 32'h99, 32'h1F));

        // lw $4; rs=$0 with exmemDest=0; rt=$7 from WB
        setInstr(5'd0, 32'h1234, 5'd7, 32'h4321, 5'd4, 4'd0);
        idIsLoad = 1; idShift = 1;
        exmemRegWrite = 1; exmemDest = 5'd0; exmemValue = 32'h22;
        memwbRegWrite = 1; memwbDest = 5'd7; memwbValue = 32'h33;
        issue(capExp("zeroAndWb", 0, 32'h1234, 32'h33, 32'd0));

        // Consumer of $4 right behind the load: stall and bubble
        setInstr(5'd9, 32'd9, 5'd4, 32'd1, 5'd8, 4'd1);
        idUsesRs = 0;
        exmemRegWrite = 0; memwbRegWrite = 0;
        issue(bubbleExp("loadUse", 1));

        // Same instruction again, load data now in MEM
        exmemRegWrite = 1; exmemDest = 5'd4; exmemValue = 32'h77;
        t6 = capExp("afterStall", 0, 32'd9, 32'h77, 32'd0);
        issue(t6);
`ifdef HAZARD_COUNT_EN
        check("stallCount1", stallCount, 32'd1);
`endif

        // Hold for three cycles with different ID inputs
        setInstr(5'd1, 32'hF00D, 5'd2, 32'hBEEF, 5'd9, 4'd7);
        exmemRegWrite = 0;
        hold = 1;
        t6.stall = 1;
        for (int i = 0; i < 3; i++) begin
            t6.name = $sformatf("hold%0d", i);
            issue(t6);
        end

        hold = 0; flush = 1;
        issue(bubbleExp("flush", 0));

        // lw $10, then flush against a load-use: bubble without stall
        flush = 0;
        setInstr(5'd1, 32'd11, 5'd2, 32'd12, 5'd10, 4'd0);
        idIsLoad = 1;
        issue(capExp("lw10", 0, 32'd11, 32'd12, 32'd0));
        setInstr(5'd10, 32'd0, 5'd0, 32'd0, 5'd13, 4'd1);
        idUsesRt = 0; flush = 1;
        issue(bubbleExp("flushLoadUse", 0));
        flush = 0;
        setInstr(5'd1, 32'd11, 5'd2, 32'd12, 5'd10, 4'd0);
        idIsLoad = 1;
        issue(capExp("lw10b", 0, 32'd11, 32'd12, 32'd0));
        setInstr(5'd10, 32'd0, 5'd0, 32'd0, 5'd13, 4'd1);
        idUsesRt = 0;
        issue(bubbleExp("loadUse2", 1));
`ifdef HAZARD_COUNT_EN
        check("stallCount2", stallCount, 32'd2);
`endif

        // add $12, then jal-style link reading $12
        setInstr(5'd1, 32'd1, 5'd2, 32'd2, 5'd12, 4'd2);
        issue(capExp("add12", 0, 32'd1, 32'd2, 32'd0));
        setInstr(5'd12, 32'h1111, 5'd3, 32'h5, 5'd31, 4'd2);
        idLink = 1; idPcPlus4 = 32'h0040_0008; exAluResult = 32'hBEEF;
        issue(capExp("link", 0, 32'h0040_0008, 32'd0, 32'd0));

        clearInputs();
        idRsData = 32'h5A5A; idDestAddr = 5'd3; idRegWrite = 1;
        issue(bubbleExp("idInvalid", 0));
        clearInputs();

        for (int i = 0; i < 20 && sbQ.size() != 0; i++) @(posedge clk);
        if (sbQ.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending expected 0", sbQ.size());
        end
        repeat (2) @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
